// File: rtl/wb_pkg.sv
// Shared encodings and entry type for the write-back select stage.
package wb_pkg;

    // Upper bound on XLEN; entries carry this many data bits and the stage uses the low XLEN.
    localparam int unsigned XLEN_MAX = 64;

    localparam int unsigned SRC_PC  = 0;
    localparam int unsigned SRC_ALU = 1;
    localparam int unsigned SRC_MEM = 2;
    localparam int unsigned SRC_IMM = 3;
    localparam int unsigned SRC_CSR = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [XLEN_MAX-1:0] data;
        logic [4:0]          rd;
        logic                we;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load byte/halfword alignment and extension of the MEM source.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] mem,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = mem >> {off, 3'b000};
        case (funct3)
            F3_LB:   data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LH:   data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: data = mem;
        endcase
    end

endmodule

// File: rtl/wb_select_stage.sv
// Registered write-back source select with a 2-entry skid buffer and flush.
// Define LOAD_ALIGN_EN to align/extend the MEM source for sub-word loads.
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SEL_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_SRC*XLEN-1:0] src_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic [4:0]              rd_in,
    input  logic                    we_in,
    input  logic [2:0]              ld_funct3,
    input  logic [1:0]              ld_off,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         wb_data,
    output logic [4:0]              wb_rd,
    output logic                    wb_we
);

    // Keeps the MEM slice in range when NUM_SRC does not include a MEM source.
    localparam int unsigned MEM_IDX = (SRC_MEM < NUM_SRC) ? SRC_MEM : 0;

    logic [XLEN-1:0] mem_aligned;
    logic [XLEN-1:0] sel_data;
    wb_entry_t       in_entry;
    wb_entry_t       oreg_q, oreg_d, skid_q, skid_d;
    logic            oreg_valid_q, oreg_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            in_ready_q;
    logic            accept;
    logic            unused_oreg_bits;

`ifdef LOAD_ALIGN_EN
    wb_load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .mem   (src_data[MEM_IDX*XLEN +: XLEN]),
        .funct3(ld_funct3),
        .off   (ld_off),
        .data  (mem_aligned)
    );
`else
    logic unused_ld;
    assign unused_ld   = ^{ld_funct3, ld_off};
    assign mem_aligned = src_data[MEM_IDX*XLEN +: XLEN];
`endif

    // Out-of-range selectors match no source and leave the data at zero.
    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data = (k == SRC_MEM) ? mem_aligned : src_data[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        in_entry                 = '0;
        in_entry.data[XLEN-1:0] = sel_data;
        in_entry.rd              = rd_in;
        in_entry.we              = we_in & (rd_in != 5'd0);
    end

    assign accept = in_valid & in_ready_q;

    always_comb begin
        oreg_d       = oreg_q;
        oreg_valid_d = oreg_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            oreg_d       = '0;
            oreg_valid_d = 1'b0;
            skid_d       = '0;
            skid_valid_d = 1'b0;
        end else if (!oreg_valid_q || out_ready) begin
            // OREG is free at this edge; SKID is older than anything offered now.
            if (skid_valid_q) begin
                oreg_d       = skid_q;
                oreg_valid_d = 1'b1;
                skid_d       = '0;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                oreg_d       = in_entry;
                oreg_valid_d = 1'b1;
            end else begin
                oreg_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oreg_q       <= '0;
            oreg_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            oreg_q       <= oreg_d;
            oreg_valid_q <= oreg_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = oreg_valid_q;
    assign wb_data   = oreg_q.data[XLEN-1:0];
    assign wb_rd     = oreg_q.rd;
    assign wb_we     = oreg_valid_q & oreg_q.we;

    // Data bits above XLEN are always zero and never leave the stage.
    assign unused_oreg_bits = ^oreg_q.data;

endmodule

// File: tb/tb_wb_select_stage.sv
// Scoreboard bench for wb_select_stage: directed entries, FIFO-ordered checking at the output.
module tb_wb_select_stage;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NUM_SRC = 5;
    localparam int unsigned SEL_W   = 3;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_SRC*XLEN-1:0] src_data;
    logic [SEL_W-1:0]        sel;
    logic [4:0]              rd_in;
    logic                    we_in;
    logic [2:0]              ld_funct3;
    logic [1:0]              ld_off;
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         wb_data;
    logic [4:0]              wb_rd;
    logic                    wb_we;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    wb_select_stage #(
        .XLEN   (XLEN),
        .NUM_SRC(NUM_SRC),
        .SEL_W  (SEL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .src_data (src_data),
        .sel      (sel),
        .rd_in    (rd_in),
        .we_in    (we_in),
        .ld_funct3(ld_funct3),
        .ld_off   (ld_off),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .wb_data  (wb_data),
        .wb_rd    (wb_rd),
        .wb_we    (wb_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_srcs(input logic [31:0] pc, input logic [31:0] alu,
                            input logic [31:0] mem, input logic [31:0] imm,
                            input logic [31:0] csr);
        src_data = {csr, imm, mem, alu, pc};
    endtask

    // Offer one entry and wait (bounded) for it to be taken; expectation is queued on accept.
    task automatic send(input logic [2:0] s, input logic [4:0] r, input logic w,
                        input logic [31:0] exp_data, input logic exp_we);
        exp_t e;
        bit   taken = 0;
        sel      = s;
        rd_in    = r;
        we_in    = w;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !taken; n++) begin
            @(negedge clk);
            if (in_ready) taken = 1;
            else @(posedge clk);
        end
        if (!taken) begin
            vectors++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for rd=%0d, expected 1", r);
        end else begin
            e.data = exp_data;
            e.rd   = r;
            e.we   = exp_we;
            sb.push_back(e);
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: an entry transfers at the next edge when valid & ready are seen mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_output: got rd=%0d data=0x%08h, expected no entry",
                         wb_rd, wb_data);
            end else begin
                e = sb.pop_front();
                chk("wb_data", wb_data, e.data);
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        sel       = '0;
        rd_in     = '0;
        we_in     = 1'b0;
        ld_funct3 = 3'b010;
        ld_off    = 2'd0;
        out_ready = 1'b0;
        set_srcs(32'h0000_0040, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0000_1000, 32'hCAFE_0000);

        // Reset for two cycles
        cycles(2);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        cycles(1);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic pass, one-cycle latency
        out_ready = 1'b1;
        send(3'd1, 5'd3, 1'b1, 32'h0000_0005, 1'b1);
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);

        // x0 guard, out-of-range select, remaining sources back to back
        send(3'd1, 5'd0, 1'b1, 32'h0000_0005, 1'b0);
        send(3'd7, 5'd4, 1'b1, 32'h0000_0000, 1'b1);
        send(3'd4, 5'd5, 1'b1, 32'hCAFE_0000, 1'b1);
        send(3'd3, 5'd6, 1'b0, 32'h0000_1000, 1'b0);
        send(3'd0, 5'd7, 1'b1, 32'h0000_0040, 1'b1);
        send(3'd5, 5'd8, 1'b1, 32'h0000_0000, 1'b1);
        cycles(3);
        chk("drain1_empty", sb.size(), 32'd0);

        // Backpressure: A into OREG, B into SKID, C held off
        out_ready = 1'b0;
        set_srcs(32'h40, 32'h1, 32'h0, 32'h0, 32'h0);
        send(3'd1, 5'd8, 1'b1, 32'h1, 1'b1);
        set_srcs(32'h40, 32'h2, 32'h0, 32'h0, 32'h0);
        send(3'd1, 5'd9, 1'b1, 32'h2, 1'b1);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        set_srcs(32'h40, 32'h3, 32'h0, 32'h0, 32'h0);
        sel      = 3'd1;
        rd_in    = 5'd10;
        in_valid = 1'b1;
        cycles(3);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_hold_data", wb_data, 32'h1);
        chk("stall_hold_rd", {27'd0, wb_rd}, 32'd8);
        out_ready = 1'b1;
        send(3'd1, 5'd10, 1'b1, 32'h3, 1'b1);
        cycles(3);
        chk("drain2_empty", sb.size(), 32'd0);

        // Flush with both entries held and a third offered
        out_ready = 1'b0;
        set_srcs(32'h40, 32'h11, 32'h0, 32'h0, 32'h0);
        send(3'd1, 5'd11, 1'b1, 32'h11, 1'b1);
        set_srcs(32'h40, 32'h12, 32'h0, 32'h0, 32'h0);
        send(3'd1, 5'd12, 1'b1, 32'h12, 1'b1);
        set_srcs(32'h40, 32'h13, 32'h0, 32'h0, 32'h0);
        rd_in    = 5'd13;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_wb_we", {31'd0, wb_we}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        cycles(4);
        set_srcs(32'h40, 32'h14, 32'h0, 32'h0, 32'h0);
        send(3'd1, 5'd14, 1'b1, 32'h14, 1'b1);
        cycles(2);

        // Load alignment on the MEM source
        set_srcs(32'h40, 32'h0, 32'h8070_F0A5, 32'h0, 32'h0);
`ifdef LOAD_ALIGN_EN
        ld_funct3 = 3'b000; ld_off = 2'd1;
        send(3'd2, 5'd15, 1'b1, 32'hFFFF_FFF0, 1'b1);
        ld_funct3 = 3'b100; ld_off = 2'd3;
        send(3'd2, 5'd16, 1'b1, 32'h0000_0080, 1'b1);
        ld_funct3 = 3'b001; ld_off = 2'd2;
        send(3'd2, 5'd17, 1'b1, 32'hFFFF_8070, 1'b1);
        ld_funct3 = 3'b010; ld_off = 2'd0;
        send(3'd2, 5'd18, 1'b1, 32'h8070_F0A5, 1'b1);
`else
        ld_funct3 = 3'b000; ld_off = 2'd1;
        send(3'd2, 5'd15, 1'b1, 32'h8070_F0A5, 1'b1);
        ld_funct3 = 3'b100; ld_off = 2'd3;
        send(3'd2, 5'd16, 1'b1, 32'h8070_F0A5, 1'b1);
        ld_funct3 = 3'b001; ld_off = 2'd2;
        send(3'd2, 5'd17, 1'b1, 32'h8070_F0A5, 1'b1);
        ld_funct3 = 3'b010; ld_off = 2'd0;
        send(3'd2, 5'd18, 1'b1, 32'h8070_F0A5, 1'b1);
`endif
        cycles(3);
        chk("drain3_empty", sb.size(), 32'd0);

        // Reset while full and stalled
        out_ready = 1'b0;
        set_srcs(32'h40, 32'h21, 32'h0, 32'h0, 32'h0);
        send(3'd1, 5'd19, 1'b1, 32'h21, 1'b1);
        set_srcs(32'h40, 32'h22, 32'h0, 32'h0, 32'h0);
        send(3'd1, 5'd20, 1'b1, 32'h22, 1'b1);
        rst = 1'b1;
        cycles(1);
        sb.delete();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_wb_data", wb_data, 32'd0);
        chk("mid_rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("mid_rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        cycles(1);
        chk("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        cycles(3);
        chk("after_rst_out_valid", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
